// File: rtl/sprite_pkg.sv
// Shared constants for the sprite blitter address path.
// Frame geometry, sprite size and address widths.
package sprite_pkg;

    localparam int unsigned FRAME_W      = 320;
    localparam int unsigned FRAME_H      = 240;
    localparam int unsigned FRAME_PIXELS = FRAME_W * FRAME_H;
    localparam int unsigned SPR_LOG2     = 3;
    localparam int unsigned ADDR_W       = 17;
    localparam int unsigned CNT_W        = 2 * SPR_LOG2;

endpackage

// File: rtl/sprite_row_offset.sv
// Combinational row*FRAME_W via constant shift-add, one term per set bit.
// Ports: row_i (sprite row), offset_o (row * FRAME_W).
import sprite_pkg::*;

module sprite_row_offset #(
    parameter int unsigned FRAME_W = 320,
    parameter int unsigned ROW_W   = 3,
    parameter int unsigned OUT_W   = 18
) (
    input  logic [ROW_W-1:0] row_i,
    output logic [OUT_W-1:0] offset_o
);

    localparam int unsigned NB = $clog2(FRAME_W) + 1;

    logic [OUT_W-1:0] row_ext;
    logic [OUT_W-1:0] term [NB];

    assign row_ext = {{(OUT_W-ROW_W){1'b0}}, row_i};

    genvar b;
    generate
        for (b = 0; b < NB; b++) begin : g_bit
            if (((FRAME_W >> b) & 1) != 0) begin : g_set
                assign term[b] = row_ext << b;
            end else begin : g_clr
                assign term[b] = '0;
            end
        end
    endgenerate

    always_comb begin
        offset_o = '0;
        for (int i = 0; i < NB; i++) begin
            offset_o = offset_o + term[i];
        end
    end

endmodule

// File: rtl/sprite_addr_calc.sv
// Sprite pixel address generator: coordinates + row*FRAME_W + col, one
// registered stage. Optional off-screen flag under SPRITE_ADDR_CLIP_EN.
// Ports: clk, rst_n (async low), coordinates, counter, in_valid ->
//        frame_addr, out_valid, clipped (0 unless SPRITE_ADDR_CLIP_EN).
import sprite_pkg::*;

module sprite_addr_calc (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] coordinates,
    input  logic [CNT_W-1:0]  counter,
    input  logic              in_valid,
    output logic [ADDR_W-1:0] frame_addr,
    output logic              out_valid,
    output logic              clipped
);

    logic [SPR_LOG2-1:0] row;
    logic [SPR_LOG2-1:0] col;
    logic [ADDR_W:0]     row_off;
    logic [ADDR_W:0]     sum_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                valid_q;

    assign row = counter[CNT_W-1:SPR_LOG2];
    assign col = counter[SPR_LOG2-1:0];

    sprite_row_offset #(
        .FRAME_W (FRAME_W),
        .ROW_W   (SPR_LOG2),
        .OUT_W   (ADDR_W + 1)
    ) u_row_off (
        .row_i    (row),
        .offset_o (row_off)
    );

    // Extra carry bit keeps the unwrapped sum for the clip compare.
    assign sum_d = {1'b0, coordinates} + row_off
                 + {{(ADDR_W+1-SPR_LOG2){1'b0}}, col};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                addr_q <= sum_d[ADDR_W-1:0];
            end
        end
    end

`ifdef SPRITE_ADDR_CLIP_EN
    localparam logic [ADDR_W:0] FRAME_END = FRAME_PIXELS[ADDR_W:0];

    logic clip_d;
    logic clip_q;

    assign clip_d = (sum_d >= FRAME_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_q <= 1'b0;
        end else if (in_valid) begin
            clip_q <= clip_d;
        end
    end

    assign clipped = clip_q;
`else
    assign clipped = 1'b0;
`endif

    assign frame_addr = addr_q;
    assign out_valid  = valid_q;

endmodule

// File: tb/tb_sprite_addr_calc.sv
// Directed bench for sprite_addr_calc with hand-computed addresses.
module tb_sprite_addr_calc;

    logic        clk;
    logic        rst_n;
    logic [16:0] coordinates;
    logic [5:0]  counter;
    logic        in_valid;
    logic [16:0] frame_addr;
    logic        out_valid;
    logic        clipped;

    int errors;
    int checks;

`ifdef SPRITE_ADDR_CLIP_EN
    localparam logic CLIP_ON = 1'b1;
`else
    localparam logic CLIP_ON = 1'b0;
`endif

    sprite_addr_calc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coordinates (coordinates),
        .counter     (counter),
        .in_valid    (in_valid),
        .frame_addr  (frame_addr),
        .out_valid   (out_valid),
        .clipped     (clipped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply(input int c, input int n, input logic v);
        coordinates = 17'(c);
        counter     = 6'(n);
        in_valid    = v;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int a,
                              input logic v, input logic cl);
        check({tag, ".addr"}, int'(frame_addr), a);
        check({tag, ".valid"}, int'(out_valid), int'(v));
        check({tag, ".clip"}, int'(clipped), int'(cl));
    endtask

    initial begin
        int exp_a;
        int pulses;
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        coordinates = '0;
        counter     = '0;
        in_valid    = 1'b0;
        #12;
        expect_out("reset", 0, 1'b0, 1'b0);
        #10;
        rst_n = 1'b1;

        apply(0, 0, 1'b1);
        expect_out("zero", 0, 1'b1, 1'b0);

        apply(0, 63, 1'b1);
        expect_out("last_px", 2247, 1'b1, 1'b0);

        apply(1000, 9, 1'b1);
        expect_out("r1c1", 1321, 1'b1, 1'b0);

        apply(5, 5, 1'b0);
        expect_out("hold", 1321, 1'b0, 1'b0);

        apply(76799, 0, 1'b1);
        expect_out("edge_in", 76799, 1'b1, 1'b0);

        apply(76799, 1, 1'b1);
        expect_out("edge_out", 76800, 1'b1, CLIP_ON);

        apply(131071, 1, 1'b1);
        expect_out("overflow", 0, 1'b1, CLIP_ON);

        apply(0, 0, 1'b0);
        expect_out("clip_hold", 0, 1'b0, CLIP_ON);

        pulses = 0;
        for (int i = 0; i < 64; i++) begin
            apply(2000, i, 1'b1);
            exp_a = 2000 + (i / 8) * 320 + (i % 8);
            check("stream.addr", int'(frame_addr), exp_a);
            if (out_valid) pulses++;
        end
        check("stream.pulses", pulses, 64);

        coordinates = 17'd3000;
        counter     = 6'd10;
        in_valid    = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 0, 1'b0, 1'b0);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        expect_out("post_rst", 0, 1'b0, 1'b0);

        apply(3000, 10, 1'b1);
        expect_out("resume", 3322, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
